// File: rtl/mode_apply.sv
// mode_apply: commits a debounced switch-panel mode on a video frame edge.
// A legal mode code must hold steady for STABLE_CYCLES cycles. The block then
// waits for a vsync rising edge and hands the mode to the gesture pipeline
// over a req/ack handshake. active_mode changes only after the pipeline acks.
//
// state   | meaning
// IDLE    | active_mode matches mode_in (or mode_in is illegal), nothing pending
// SETTLE  | candidate mode seen, counting stable cycles
// WAIT_VS | candidate committed, waiting for a frame boundary
// REQ     | cfg_req raised, waiting for cfg_ack or timeout
module mode_apply #(
  parameter int STABLE_CYCLES = 50000,
  parameter int ACK_TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] mode_in,
  input  logic       vsync,
  input  logic       cfg_ack,
  output logic       cfg_req,
  output logic [3:0] cfg_mode,
  output logic [3:0] active_mode,
  output logic       mode_changed,
  output logic       busy,
  output logic       err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_WAIT_VS = 2'd2;
  localparam logic [1:0] S_REQ     = 2'd3;

  // Terminal counts; both counters stop here, so they never wrap.
  localparam logic [19:0] STABLE_LAST = 20'(STABLE_CYCLES - 1);
  localparam logic [15:0] ACK_LAST    = 16'(ACK_TIMEOUT - 1);

  logic [1:0]  state;
  logic [3:0]  cand;
  logic [19:0] cnt;
  logic [15:0] tcnt;
  logic        vsync_d;
  logic        vs_rise;
  logic        mode_legal;

  assign vs_rise    = vsync & ~vsync_d;
  assign mode_legal = (mode_in < 4'd7);
  assign busy       = (state != S_IDLE);

  // Delayed vsync for edge detection; resets high so a level-high vsync at
  // reset release does not look like a frame edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d <= 1'b1;
    end else begin
      vsync_d <= vsync;
    end
  end

  // Sequencing FSM: settle, frame alignment, handshake and commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cand         <= 4'd0;
      cnt          <= 20'd0;
      tcnt         <= 16'd0;
      cfg_req      <= 1'b0;
      cfg_mode     <= 4'd0;
      active_mode  <= 4'd0;
      mode_changed <= 1'b0;
      err          <= 1'b0;
    end else begin
      mode_changed <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mode_legal && (mode_in != active_mode)) begin
            cand  <= mode_in;
            cnt   <= 20'd0;
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!mode_legal || (mode_in == active_mode)) begin
            state <= S_IDLE;
          end else if (mode_in != cand) begin
            // Switch bounced to another legal code: restart the stability window.
            cand <= mode_in;
            cnt  <= 20'd0;
          end else if (cnt == STABLE_LAST) begin
            state <= S_WAIT_VS;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        S_WAIT_VS: begin
          if (vs_rise) begin
            cfg_req  <= 1'b1;
            cfg_mode <= cand;
            tcnt     <= 16'd0;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          // Ack takes priority over a simultaneous timeout.
          if (cfg_ack) begin
            active_mode  <= cfg_mode;
            cfg_req      <= 1'b0;
            mode_changed <= 1'b1;
            state        <= S_IDLE;
          end else if (tcnt == ACK_LAST) begin
            cfg_req <= 1'b0;
            err     <= 1'b1;
            state   <= S_IDLE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mode_apply.sv
// tb_mode_apply: directed scenarios plus random stimulus, scored against a
// run-length reference model of the mode-apply behaviour.
module tb_mode_apply;

  localparam int S = 4;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mode_in = 4'd0;
  logic       vsync = 1'b1;
  logic       cfg_ack = 1'b0;
  logic       cfg_req;
  logic [3:0] cfg_mode;
  logic [3:0] active_mode;
  logic       mode_changed;
  logic       busy;
  logic       err;

  mode_apply #(.STABLE_CYCLES(S), .ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .mode_in(mode_in), .vsync(vsync), .cfg_ack(cfg_ack),
    .cfg_req(cfg_req), .cfg_mode(cfg_mode), .active_mode(active_mode),
    .mode_changed(mode_changed), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Reference model: a request goes out at the first vsync rise after a legal,
  // non-active code has been sampled S+1 times in a row while nothing else is
  // pending; it completes on ack or is abandoned after T unanswered samples.
  localparam int M_WATCH = 0;
  localparam int M_ARMED = 1;
  localparam int M_REQ   = 2;

  int         m_phase;
  int         m_run;
  int         m_wait;
  logic [3:0] m_val;
  logic [3:0] m_cand;
  logic [3:0] m_active;
  logic       m_err;
  logic       m_vs_prev;
  logic       m_rise;
  logic [3:0] exp_req_q[$];
  logic [3:0] exp_chg_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = M_WATCH; m_run = 0; m_wait = 0; m_val = 0; m_cand = 0;
      m_active = 0; m_err = 0; m_vs_prev = 1'b1;
      exp_req_q.delete(); exp_chg_q.delete();
    end else begin
      m_rise = vsync && !m_vs_prev;
      m_vs_prev = vsync;
      if (m_phase == M_WATCH) begin
        if (mode_in <= 4'd6 && mode_in != m_active) begin
          if (m_run > 0 && mode_in == m_val) m_run++;
          else begin m_val = mode_in; m_run = 1; end
          if (m_run == S + 1) begin m_phase = M_ARMED; m_cand = m_val; end
        end else begin
          m_run = 0;
        end
      end else if (m_phase == M_ARMED) begin
        if (m_rise) begin
          m_phase = M_REQ; m_wait = 0; exp_req_q.push_back(m_cand);
        end
      end else begin
        if (cfg_ack) begin
          m_active = m_cand; exp_chg_q.push_back(m_cand);
          m_phase = M_WATCH; m_run = 0;
        end else begin
          m_wait++;
          if (m_wait == T) begin m_err = 1'b1; m_phase = M_WATCH; m_run = 0; end
        end
      end
    end
  end

  // Monitor: per-cycle level checks plus scoreboard pops on output events.
  logic       prev_req = 1'b0;
  int         req_len = 0;
  int         last_req_len = 0;
  int         n_req = 0;
  logic [3:0] last_req_mode = 4'd0;

  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0; req_len = 0;
    end else begin
      check("cfg_req", cfg_req, m_phase == M_REQ);
      check("busy", busy, (m_phase != M_WATCH) || (m_run > 0));
      check("active_mode", active_mode, m_active);
      check("err", err, m_err);
      if (cfg_req && !prev_req) begin
        n_req++;
        last_req_mode = cfg_mode;
        if (exp_req_q.size() == 0) fail_now("unexpected_cfg_req");
        else check("cfg_mode_at_req", cfg_mode, exp_req_q.pop_front());
      end
      if (cfg_req) begin
        req_len++;
        check("cfg_mode_stable", cfg_mode, m_cand);
      end
      if (!cfg_req && prev_req) begin
        last_req_len = req_len;
        check("req_len_bound", req_len <= T, 1);
        req_len = 0;
      end
      if (mode_changed) begin
        if (exp_chg_q.size() == 0) fail_now("unexpected_mode_changed");
        else check("mode_changed_value", active_mode, exp_chg_q.pop_front());
      end else if (exp_chg_q.size() != 0) begin
        fail_now("missing_mode_changed");
        exp_chg_q.delete();
      end
      prev_req = cfg_req;
    end
  end

  // Pipeline responder: acks a configurable number of cycles after cfg_req.
  logic ack_en = 1'b1;
  logic stray_en = 1'b0;
  int   ack_dly = 2;
  int   rcnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      cfg_ack = 1'b0; rcnt = 0;
    end else if (cfg_req) begin
      cfg_ack = ack_en && (rcnt == ack_dly);
      rcnt++;
    end else begin
      rcnt = 0;
      cfg_ack = stray_en && ($urandom_range(0, 5) == 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vs_pulse();
    vsync = 1'b0;
    cyc(2);
    vsync = 1'b1;
  endtask

  initial begin
    int n0;
    int w;

    // Reset with vsync high.
    rst = 1'b1; vsync = 1'b1;
    cyc(3);
    check("rst_cfg_req", cfg_req, 0);
    check("rst_cfg_mode", cfg_mode, 0);
    check("rst_active_mode", active_mode, 0);
    check("rst_mode_changed", mode_changed, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    cyc(10);
    check("no_req_after_reset", n_req, 0);

    // Basic change to mode 1.
    mode_in = 4'd1;
    cyc(20);
    vs_pulse();
    cyc(15);
    check("basic_active", active_mode, 1);
    check("basic_req_mode", last_req_mode, 1);
    check("basic_req_count", n_req, 1);
    check("basic_busy", busy, 0);

    // Bounce 2 -> 4; only 4 may be requested.
    n0 = n_req;
    mode_in = 4'd2; vsync = 1'b0;
    cyc(2);
    mode_in = 4'd4;
    cyc(7);
    vsync = 1'b1;
    cyc(15);
    check("bounce_req_mode", last_req_mode, 4);
    check("bounce_req_count", n_req - n0, 1);
    check("bounce_active", active_mode, 4);

    // Bounce back to the active mode before it settles.
    n0 = n_req;
    mode_in = 4'd5;
    cyc(3);
    mode_in = 4'd4;
    cyc(20);
    vs_pulse();
    cyc(10);
    check("bounceback_req_count", n_req - n0, 0);
    check("bounceback_active", active_mode, 4);
    check("bounceback_busy", busy, 0);

    // Illegal code.
    mode_in = 4'd9;
    cyc(50);
    vs_pulse();
    cyc(50);
    check("illegal_req_count", n_req - n0, 0);
    check("illegal_busy", busy, 0);

    // Timeout, then automatic retry on the next frame.
    ack_en = 1'b0;
    mode_in = 4'd6;
    cyc(10);
    vs_pulse();
    cyc(20);
    check("timeout_req_len", last_req_len, T);
    check("timeout_err", err, 1);
    check("timeout_active", active_mode, 4);
    ack_en = 1'b1; ack_dly = 1;
    vs_pulse();
    cyc(15);
    check("retry_active", active_mode, 6);
    check("retry_err_sticky", err, 1);

    // Reset while a request is outstanding.
    ack_en = 1'b0;
    mode_in = 4'd3;
    cyc(10);
    vs_pulse();
    w = 0;
    while (!cfg_req && w < 100) begin cyc(1); w++; end
    check("midrst_req_seen", cfg_req, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_cfg_req", cfg_req, 0);
    check("midrst_active", active_mode, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Ack on the same sample as the timeout: ack wins.
    ack_en = 1'b1; ack_dly = T - 1;
    mode_in = 4'd2;
    cyc(10);
    vs_pulse();
    cyc(20);
    check("ackwin_active", active_mode, 2);
    check("ackwin_err", err, 0);
    check("ackwin_req_len", last_req_len, T);

    // Random stimulus with stray acks outside REQ.
    stray_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int hold;
      mode_in = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(0, 15));
      hold    = $urandom_range(1, 12);
      ack_en  = ($urandom_range(0, 3) != 0);
      ack_dly = $urandom_range(0, 9);
      for (int k = 0; k < hold; k++) begin
        if ($urandom_range(0, 3) == 0) vsync = ~vsync;
        cyc(1);
      end
    end
    stray_en = 1'b0; ack_en = 1'b1; ack_dly = 0;
    cyc(30);
    check("req_queue_drained", exp_req_q.size(), 0);
    check("chg_queue_drained", exp_chg_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
